// File: rtl/ql_timing_pkg.sv
// Shared timing definitions for the QL bus timer: speed modes, default
// divider settings and the width helper used to size its counters.
package ql_timing_pkg;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        X2     = 2'd1,
        X4     = 2'd2,
        RSVD   = 2'd3
    } speed_t;

    localparam int DEF_BUS_DIV     = 8;
    localparam int DEF_FRAME_SLOTS = 4;
    localparam int DEF_TICK_DIV    = 641;
    localparam int DEF_RST_LEN     = 4095;

    // Bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/ql_bus_timer_if.sv
// Bus-timing bundle between the QL timer and its consumers.
// Optional statistics signals exist only when QL_BUS_STATS_EN is defined.
interface ql_bus_timer_if;

    logic [1:0] speed;
    logic       rst_req;
    logic       stall_in;

    logic       ce_p;
    logic       ce_n;
    logic       ce_vid;
    logic       ce_sd;
    logic       ce_tick;
    logic       duty_cycle;
    logic       cpu_cycle;
    logic       ce_bus_p;
    logic       ce_bus_n;
    logic       sys_reset;

`ifdef QL_BUS_STATS_EN
    logic [31:0] slot_count;
    logic [15:0] stall_count;

    modport master (
        input  speed, rst_req, stall_in,
        output ce_p, ce_n, ce_vid, ce_sd, ce_tick, duty_cycle, cpu_cycle,
               ce_bus_p, ce_bus_n, sys_reset, slot_count, stall_count
    );

    modport slave (
        output speed, rst_req, stall_in,
        input  ce_p, ce_n, ce_vid, ce_sd, ce_tick, duty_cycle, cpu_cycle,
               ce_bus_p, ce_bus_n, sys_reset, slot_count, stall_count
    );
`else
    modport master (
        input  speed, rst_req, stall_in,
        output ce_p, ce_n, ce_vid, ce_sd, ce_tick, duty_cycle, cpu_cycle,
               ce_bus_p, ce_bus_n, sys_reset
    );

    modport slave (
        output speed, rst_req, stall_in,
        input  ce_p, ce_n, ce_vid, ce_sd, ce_tick, duty_cycle, cpu_cycle,
               ce_bus_p, ce_bus_n, sys_reset
    );
`endif

endinterface

// File: rtl/ql_reset_stretch.sv
// Stretches any reset request into a sys_reset lasting RST_LEN bus
// phases (ce_p pulses) after the request goes away.
module ql_reset_stretch
    import ql_timing_pkg::*;
#(
    parameter int RST_LEN = DEF_RST_LEN
) (
    input  logic clk_sys,
    input  logic RESET,
    input  logic rst_req,
    input  logic ce_p,
    output logic sys_reset
);

    localparam int RC_W = clog2(RST_LEN + 1);

    logic [RC_W-1:0] rcnt;

    // A request arriving mid-count simply reloads the full length.
    always_ff @(posedge clk_sys) begin
        if (RESET || rst_req) begin
            rcnt      <= RC_W'(RST_LEN);
            sys_reset <= 1'b1;
        end else begin
            if (ce_p && (rcnt != '0)) rcnt <= rcnt - RC_W'(1);
            sys_reset <= (rcnt != '0);
        end
    end

endmodule

// File: rtl/ql_bus_timer.sv
// QL clock-enable, CPU bus-slot arbitration and reset sequencing.
// Define QL_BUS_STATS_EN to add granted-slot and stalled-slot counters.
module ql_bus_timer
    import ql_timing_pkg::*;
#(
    parameter int BUS_DIV     = DEF_BUS_DIV,
    parameter int FRAME_SLOTS = DEF_FRAME_SLOTS,
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int RST_LEN     = DEF_RST_LEN
) (
    input  logic           clk_sys,
    input  logic           RESET,
    ql_bus_timer_if.master bus
);

    localparam int CNT_W  = clog2(BUS_DIV * FRAME_SLOTS);
    localparam int PH_W   = clog2(BUS_DIV);
    localparam int SL_W   = CNT_W - PH_W;
    localparam int HALF_W = PH_W - 1;
    localparam int TICK_W = clog2(TICK_DIV);
    localparam logic [PH_W-1:0]   PH_HALF   = PH_W'(BUS_DIV / 2);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic [CNT_W-1:0]  cnt;
    logic [PH_W-1:0]   phase;
    logic [SL_W-1:0]   slot;
    logic              frame_start;
    logic              slot_start;

    speed_t            speed_act;
    speed_t            speed_eff;
    logic              sub;
    logic              sub_nxt;
    logic              duty_nxt;
    logic              eligible;
    logic              grant;

    logic              ce_p;
    logic              ce_n;
    logic              ce_sd;
    logic              duty;
    logic              cpu;

    logic [TICK_W-1:0] tcnt;
    logic              tick_armed;
    logic              ce_tick;
    logic              sys_reset;

    assign phase       = cnt[PH_W-1:0];
    assign slot        = cnt[CNT_W-1:PH_W];
    assign frame_start = (cnt == '0);
    assign slot_start  = (phase == '0);

    // At a frame boundary the incoming speed already governs slot 0.
    always_comb begin
        speed_eff = frame_start ? speed_t'(bus.speed) : speed_act;
        duty_nxt  = 1'b1;
        case (speed_eff)
            NORMAL:  duty_nxt = (slot == '0);
            X2:      duty_nxt = ~slot[0];
            default: duty_nxt = 1'b1;
        endcase
        sub_nxt = sub;
        if (frame_start) sub_nxt = (speed_eff == NORMAL) ? ~sub : 1'b1;
        eligible = duty_nxt & sub_nxt;
        grant    = eligible & ~bus.stall_in;
    end

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            cnt       <= '0;
            speed_act <= NORMAL;
            sub       <= 1'b0;
            duty      <= 1'b0;
            cpu       <= 1'b0;
            ce_p      <= 1'b0;
            ce_n      <= 1'b0;
            ce_sd     <= 1'b0;
        end else begin
            cnt   <= cnt + CNT_W'(1);
            ce_p  <= slot_start;
            ce_n  <= (phase == PH_HALF);
            ce_sd <= (phase[HALF_W-1:0] == '0);
            if (frame_start) begin
                speed_act <= speed_eff;
                sub       <= sub_nxt;
            end
            if (slot_start) begin
                duty <= duty_nxt;
                cpu  <= grant;
            end
        end
    end

    // The idle count of 0 straight out of reset does not produce a tick.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            tcnt       <= '0;
            tick_armed <= 1'b0;
            ce_tick    <= 1'b0;
        end else begin
            tcnt       <= (tcnt == TICK_LAST) ? '0 : tcnt + TICK_W'(1);
            tick_armed <= 1'b1;
            ce_tick    <= tick_armed && (tcnt == '0);
        end
    end

    ql_reset_stretch #(
        .RST_LEN (RST_LEN)
    ) u_reset_stretch (
        .clk_sys   (clk_sys),
        .RESET     (RESET),
        .rst_req   (bus.rst_req),
        .ce_p      (ce_p),
        .sys_reset (sys_reset)
    );

    assign bus.ce_p       = ce_p;
    assign bus.ce_n       = ce_n;
    assign bus.ce_vid     = ce_p;
    assign bus.ce_sd      = ce_sd;
    assign bus.ce_tick    = ce_tick;
    assign bus.duty_cycle = duty;
    assign bus.cpu_cycle  = cpu;
    assign bus.ce_bus_p   = duty & ce_p;
    assign bus.ce_bus_n   = duty & ce_n;
    assign bus.sys_reset  = sys_reset;

`ifdef QL_BUS_STATS_EN
    logic [31:0] slot_count;
    logic [15:0] stall_count;

    always_ff @(posedge clk_sys) begin
        if (RESET || sys_reset) begin
            slot_count  <= '0;
            stall_count <= '0;
        end else if (slot_start) begin
            if (grant && (slot_count != '1)) slot_count <= slot_count + 32'd1;
            if (eligible && bus.stall_in && (stall_count != '1))
                stall_count <= stall_count + 16'd1;
        end
    end

    assign bus.slot_count  = slot_count;
    assign bus.stall_count = stall_count;
`endif

endmodule

// File: tb/tb_ql_bus_timer.sv
// Randomised bench for ql_bus_timer against a frame/slot-level reference model.
module tb_ql_bus_timer;

    localparam int BUS_DIV     = 8;
    localparam int FRAME_SLOTS = 4;
    localparam int TICK_DIV    = 641;
    localparam int RST_LEN     = 16;
    localparam int FRAME       = BUS_DIV * FRAME_SLOTS;

    logic clk_sys = 1'b0;
    logic RESET   = 1'b1;

    always #5 clk_sys = ~clk_sys;

    ql_bus_timer_if bus_if ();

    ql_bus_timer #(
        .BUS_DIV     (BUS_DIV),
        .FRAME_SLOTS (FRAME_SLOTS),
        .TICK_DIV    (TICK_DIV),
        .RST_LEN     (RST_LEN)
    ) dut (
        .clk_sys (clk_sys),
        .RESET   (RESET),
        .bus     (bus_if)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: edges since reset, speed latched per frame, grant parity.
    int e         = 0;
    int fspeed    = 0;
    bit tog       = 1'b0;
    bit m_duty    = 1'b0;
    bit m_cpu     = 1'b0;
    int n_p, n_sd, n_cpu, n_busp, n_duty;
    int ticks     = 0;
    int last_tick = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit slot_eligible(input int sp, input int sl);
        if (sp == 0) return sl == 0;
        if (sp == 1) return (sl % 2) == 0;
        return 1'b1;
    endfunction

    task automatic clear_counts();
        n_p = 0; n_sd = 0; n_cpu = 0; n_busp = 0; n_duty = 0;
    endtask

    task automatic step();
        logic [1:0] sp;
        logic       st;
        logic       rs;
        int         c;
        int         ph;
        bit         xp, xn, xsd, xt;
        sp = bus_if.speed;
        st = bus_if.stall_in;
        rs = RESET;
        @(posedge clk_sys);
        #1;
        c  = -1;
        ph = -1;
        if (rs) begin
            e = 0; fspeed = 0; tog = 1'b0; m_duty = 1'b0; m_cpu = 1'b0;
            last_tick = -1;
        end else begin
            e++;
            c  = (e - 1) % FRAME;
            ph = c % BUS_DIV;
            if (c == 0) begin
                fspeed = int'(sp);
                tog    = (fspeed == 0) ? !tog : 1'b1;
            end
            if (ph == 0) begin
                m_duty = slot_eligible(fspeed, c / BUS_DIV);
                m_cpu  = m_duty && tog && !st;
            end
        end
        xp  = (ph == 0);
        xn  = (ph == BUS_DIV / 2);
        xsd = (ph >= 0) && ((ph % (BUS_DIV / 2)) == 0);
        xt  = !rs && (e > 1) && (((e - 1) % TICK_DIV) == 0);
        check("ce_p",       bus_if.ce_p,       xp);
        check("ce_n",       bus_if.ce_n,       xn);
        check("ce_vid",     bus_if.ce_vid,     xp);
        check("ce_sd",      bus_if.ce_sd,      xsd);
        check("ce_tick",    bus_if.ce_tick,    xt);
        check("duty_cycle", bus_if.duty_cycle, m_duty);
        check("cpu_cycle",  bus_if.cpu_cycle,  m_cpu);
        check("ce_bus_p",   bus_if.ce_bus_p,   m_duty && xp);
        check("ce_bus_n",   bus_if.ce_bus_n,   m_duty && xn);
        if (rs) check("sys_reset_in_reset", bus_if.sys_reset, 1);
        if (bus_if.ce_p)       n_p++;
        if (bus_if.ce_sd)      n_sd++;
        if (bus_if.cpu_cycle)  n_cpu++;
        if (bus_if.ce_bus_p)   n_busp++;
        if (bus_if.duty_cycle) n_duty++;
        if (bus_if.ce_tick) begin
            if (last_tick >= 0) check("tick_spacing", e - last_tick, TICK_DIV);
            last_tick = e;
            ticks++;
        end
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while (((e % FRAME) != target) && (guard < 2 * FRAME)) begin
            step();
            guard++;
        end
    endtask

    task automatic wait_release(output int n);
        n = 0;
        while ((bus_if.sys_reset === 1'b1) && (n < 400)) begin
            step();
            n++;
        end
        check("release_timeout", n < 400, 1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        int n;
        int s0;
        int st0;
        bus_if.speed    = 2'd0;
        bus_if.stall_in = 1'b0;
        bus_if.rst_req  = 1'b0;
        RESET           = 1'b1;
        clear_counts();
        repeat (3) step();
        check("rst_cpu_cycle", bus_if.cpu_cycle, 0);
        check("rst_ce_bus_p",  bus_if.ce_bus_p,  0);
        check("rst_sys_reset", bus_if.sys_reset, 1);
        RESET = 1'b0;

        clear_counts();
        repeat (256) step();
        check("n0_ce_p",   n_p,    32);
        check("n0_ce_sd",  n_sd,   64);
        check("n0_cpu",    n_cpu,  32);
        check("n0_bus_p",  n_busp, 8);

        for (int s = 1; s < 4; s++) begin
            bus_if.speed = 2'(s);
            clear_counts();
            repeat (64) step();
            check("speed_cpu_slots", n_cpu / BUS_DIV, (s == 1) ? 4 : 8);
            check("speed_bus_p",     n_busp,          (s == 1) ? 4 : 8);
        end

        bus_if.speed = 2'd0;
        run_to(0);
        run_to(10);
        bus_if.speed = 2'd2;
        clear_counts();
        repeat (22) step();
        check("duty_before_wrap", n_duty, 0);
        clear_counts();
        repeat (32) step();
        check("duty_after_wrap", n_duty, 32);

        clear_counts();
        for (int i = 0; i < FRAME; i++) begin
            bus_if.stall_in = ((e % FRAME) == BUS_DIV);
            step();
        end
        check("stall_slot_start", n_cpu, 24);
        clear_counts();
        for (int i = 0; i < FRAME; i++) begin
            bus_if.stall_in = ((e % FRAME) == BUS_DIV + 3);
            step();
        end
        bus_if.stall_in = 1'b0;
        check("stall_mid_slot", n_cpu, 32);

        check("sys_reset_idle", bus_if.sys_reset, 0);
        bus_if.rst_req = 1'b1;
        step();
        bus_if.rst_req = 1'b0;
        check("sys_reset_on_req", bus_if.sys_reset, 1);
        wait_release(n);
        check("release_window", (n >= 120) && (n <= 136), 1);

        bus_if.rst_req = 1'b1;
        step();
        bus_if.rst_req = 1'b0;
        repeat (59) step();
        check("sys_reset_held", bus_if.sys_reset, 1);
        bus_if.rst_req = 1'b1;
        step();
        bus_if.rst_req = 1'b0;
        wait_release(n);
        check("rereq_window", (n >= 120) && (n <= 136), 1);

        RESET = 1'b1;
        step();
        RESET = 1'b0;
        ticks = 0;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 39) == 0) bus_if.speed = 2'($urandom_range(0, 3));
            bus_if.stall_in = ($urandom_range(0, 7) == 0);
            step();
        end
        bus_if.stall_in = 1'b0;
        check("tick_count", ticks, 15);

        run_to(1);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        check("midrst_ce_p",      bus_if.ce_p,       0);
        check("midrst_duty",      bus_if.duty_cycle, 0);
        check("midrst_cpu",       bus_if.cpu_cycle,  0);
        check("midrst_sys_reset", bus_if.sys_reset,  1);

`ifdef QL_BUS_STATS_EN
        bus_if.speed = 2'd2;
        wait_release(n);
        run_to(0);
        s0 = int'(bus_if.slot_count);
        repeat (640) step();
        check("slot_count", bus_if.slot_count - 32'(s0), 80);
        run_to(BUS_DIV);
        st0 = int'(bus_if.stall_count);
        bus_if.stall_in = 1'b1;
        step();
        bus_if.stall_in = 1'b0;
        step();
        check("stall_count", 32'(bus_if.stall_count) - 32'(st0), 1);
`else
        s0  = 0;
        st0 = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
